// File: rtl/ps2_frame_decoder.sv
// PS/2 keyboard receive front end: synchronises and glitch-filters the raw lines,
// frames 11-bit packets (start, 8 data LSB-first, odd parity, stop), applies a
// stall timeout, and folds E0/F0 prefix bytes into flags on one qualified event.
module ps2_frame_decoder #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       keyb_clk,
   input  logic       kdata,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_err,
   output logic [1:0] err_type,
   output logic       busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          filt_clk, filt_prev;
   logic [7:0]    filt_cnt;
   logic          sample;
   state_t        state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          ext_pend, brk_pend;

   // Two-flop synchronisers; lines idle high so reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= keyb_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= kdata;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock follows the synchronised clock only after FILTER_LEN
   // consecutive samples that disagree with it; any agreeing sample restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= 8'd0;
      end else begin
         filt_prev <= filt_clk;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= 8'd0;
         end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= 8'd0;
         end else begin
            filt_cnt <= filt_cnt + 8'd1;
         end
      end
   end

   // One-cycle sample event on the filtered falling edge; dat_s2 is the bit.
   always_comb begin
      sample = filt_prev & ~filt_clk;
   end

   // Frame FSM, timeout counter, prefix folding and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         bitcnt      <= 3'd0;
         shreg       <= 8'd0;
         par_bit     <= 1'b0;
         tcnt        <= '0;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         code        <= 8'd0;
         code_valid  <= 1'b0;
         is_break    <= 1'b0;
         is_extended <= 1'b0;
         frame_err   <= 1'b0;
         err_type    <= 2'b00;
         busy        <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state == StIdle) begin
            tcnt <= '0;
            if (sample && !dat_s2) begin
               state  <= StData;
               bitcnt <= 3'd0;
               busy   <= 1'b1;
            end
         end else if (sample) begin
            tcnt <= '0;
            case (state)
               StData: begin
                  shreg  <= {dat_s2, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     state <= StParity;
                  end
               end
               StParity: begin
                  par_bit <= dat_s2;
                  state   <= StStop;
               end
               StStop: begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  if (!(^{shreg, par_bit})) begin
                     frame_err <= 1'b1;
                     err_type  <= 2'b01;
                     ext_pend  <= 1'b0;
                     brk_pend  <= 1'b0;
                  end else if (!dat_s2) begin
                     frame_err <= 1'b1;
                     err_type  <= 2'b10;
                     ext_pend  <= 1'b0;
                     brk_pend  <= 1'b0;
                  end else if (shreg == 8'hE0) begin
                     ext_pend <= 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_pend <= 1'b1;
                  end else begin
                     code        <= shreg;
                     is_break    <= brk_pend;
                     is_extended <= ext_pend;
                     code_valid  <= 1'b1;
                     ext_pend    <= 1'b0;
                     brk_pend    <= 1'b0;
                  end
               end
               default: begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            endcase
         end else if (tcnt == TW'(TIMEOUT_CYC)) begin
            // Stalled frame: drop it and any pending prefix.
            state     <= StIdle;
            busy      <= 1'b0;
            tcnt      <= '0;
            frame_err <= 1'b1;
            err_type  <= 2'b11;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Bench for ps2_frame_decoder: table of directed frames, hand-written corner
// sequences (glitches, timeout, mid-frame reset) and random frames checked
// against a byte-level reference model.
module tb_ps2_frame_decoder;

   localparam int unsigned FILT = 8;
   localparam int unsigned TO   = 2000;
   localparam int          HALF = 30;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       keyb_clk = 1'b1;
   logic       kdata = 1'b1;
   logic [7:0] code;
   logic       code_valid, is_break, is_extended, frame_err, busy;
   logic [1:0] err_type;

   ps2_frame_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .keyb_clk    (keyb_clk),
      .kdata       (kdata),
      .code        (code),
      .code_valid  (code_valid),
      .is_break    (is_break),
      .is_extended (is_extended),
      .frame_err   (frame_err),
      .err_type    (err_type),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int last_fall = 0;
   int excl_viol = 0;

   typedef struct {
      bit         err;
      logic [1:0] et;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      int         cyc;
   } ev_t;

   ev_t act_q[$];
   ev_t exp_q[$];

   // Record every strobe seen on the DUT outputs.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (code_valid && frame_err) excl_viol++;
         if (code_valid || frame_err) begin
            e.err  = frame_err;
            e.et   = err_type;
            e.code = code;
            e.brk  = is_break;
            e.ext  = is_extended;
            e.cyc  = cyc;
            act_q.push_back(e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Drive the first nbits of a frame; optional 5-cycle low glitch in each high phase.
   task automatic send_bits(input logic [7:0] b, input bit pf, input bit st,
                            input int nbits, input bit glitch);
      logic [10:0] f;
      f = {st, (~^b) ^ pf, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         kdata = f[i];
         if (glitch) begin
            repeat (10) @(negedge clk);
            keyb_clk = 1'b0;
            repeat (5) @(negedge clk);
            keyb_clk = 1'b1;
            repeat (HALF - 15) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         keyb_clk  = 1'b0;
         last_fall = cyc;
         repeat (HALF) @(negedge clk);
         keyb_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      kdata = 1'b1;
   endtask

   // Reference model: one byte in, zero or one expected event out.
   bit m_ext = 1'b0;
   bit m_brk = 1'b0;
   task automatic model(input logic [7:0] b, input bit pf, input bit st);
      ev_t e;
      int  ones;
      ones = $countones(b) + (((($countones(b) % 2) == 0) ^ pf) ? 1 : 0);
      e.cyc = 0;
      e.code = 8'h00;
      e.brk = 1'b0;
      e.ext = 1'b0;
      e.et = 2'b00;
      if ((ones % 2) == 0 || !st) begin
         e.err = 1'b1;
         e.et  = ((ones % 2) == 0) ? 2'b01 : 2'b10;
         m_ext = 1'b0;
         m_brk = 1'b0;
         exp_q.push_back(e);
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         e.err  = 1'b0;
         e.code = b;
         e.brk  = m_brk;
         e.ext  = m_ext;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic compare_events(input string name);
      int n;
      chk({name, " event count"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({name, " err"}, act_q[i].err, exp_q[i].err);
         if (exp_q[i].err) begin
            chk({name, " err_type"}, act_q[i].et, exp_q[i].et);
         end else begin
            chk({name, " code"}, act_q[i].code, exp_q[i].code);
            chk({name, " is_break"}, act_q[i].brk, exp_q[i].brk);
            chk({name, " is_extended"}, act_q[i].ext, exp_q[i].ext);
         end
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " code"}, code, 0);
      chk({name, " strobes"}, {code_valid, frame_err}, 0);
      chk({name, " flags"}, {is_break, is_extended}, 0);
      chk({name, " err_type"}, err_type, 0);
      chk({name, " busy"}, busy, 0);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         pf;
      bit         st;
      bit         ev;
      bit         err;
      logic [7:0] code;
      bit         brk;
      bit         ext;
      logic [1:0] et;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [7:0] last_code;
      logic [1:0] last_et;
      int         d;

      vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 2'b00};
      vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0, 2'b00};
      vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 1'b1, 2'b00};
      vecs[6]  = '{8'h29, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01};
      vecs[7]  = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29, 1'b0, 1'b0, 2'b00};
      vecs[8]  = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b10};
      vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[10] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[11] = '{8'h74, 1'b0, 1'b1, 1'b1, 1'b0, 8'h74, 1'b0, 1'b1, 2'b00};
      vecs[12] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[13] = '{8'h3A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b01};
      vecs[14] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 2'b00};
      vecs[15] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
      vecs[16] = '{8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'b10};
      vecs[17] = '{8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 2'b00};

      repeat (5) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Directed table.
      last_code = 8'h00;
      last_et   = 2'b00;
      for (int i = 0; i < 18; i++) begin
         send_bits(vecs[i].b, vecs[i].pf, vecs[i].st, 11, 1'b0);
         repeat (10) @(negedge clk);
         chk($sformatf("vec%0d event count", i), act_q.size(), vecs[i].ev ? 1 : 0);
         if (vecs[i].ev && act_q.size() == 1) begin
            chk($sformatf("vec%0d err", i), act_q[0].err, vecs[i].err);
            d = act_q[0].cyc - last_fall;
            chk($sformatf("vec%0d latency %0d", i, d), (d >= FILT && d <= FILT + 6), 1);
            if (vecs[i].err) begin
               chk($sformatf("vec%0d err_type", i), act_q[0].et, vecs[i].et);
            end else begin
               chk($sformatf("vec%0d code", i), act_q[0].code, vecs[i].code);
               chk($sformatf("vec%0d is_break", i), act_q[0].brk, vecs[i].brk);
               chk($sformatf("vec%0d is_extended", i), act_q[0].ext, vecs[i].ext);
            end
         end
         if (vecs[i].ev && !vecs[i].err) last_code = vecs[i].code;
         if (vecs[i].ev && vecs[i].err) last_et = vecs[i].et;
         chk($sformatf("vec%0d code hold", i), code, last_code);
         chk($sformatf("vec%0d err_type hold", i), err_type, last_et);
         act_q.delete();
      end

      // Glitches while idle must not start a frame.
      for (int g = 0; g < 3; g++) begin
         keyb_clk = 1'b0;
         repeat (5) @(negedge clk);
         keyb_clk = 1'b1;
         repeat (20) @(negedge clk);
      end
      chk("idle glitch events", act_q.size(), 0);
      chk("idle glitch busy", busy, 0);
      send_bits(8'h23, 1'b0, 1'b1, 11, 1'b1);
      repeat (10) @(negedge clk);
      exp_q.push_back('{1'b0, 2'b00, 8'h23, 1'b0, 1'b0, 0});
      compare_events("glitched 0x23");

      // Timeout: start plus four data bits, then the clock stalls high.
      send_bits(8'h1D, 1'b0, 1'b1, 5, 1'b0);
      chk("stall busy", busy, 1);
      for (int i = 0; i < int'(TO) + 300 && act_q.size() == 0; i++) @(negedge clk);
      chk("timeout event count", act_q.size(), 1);
      if (act_q.size() == 1) begin
         chk("timeout err", act_q[0].err, 1);
         chk("timeout err_type", act_q[0].et, 2'b11);
         d = act_q[0].cyc - last_fall;
         chk($sformatf("timeout latency %0d", d), (d >= int'(TO) && d <= int'(TO + FILT) + 8), 1);
      end
      act_q.delete();
      repeat (2) @(negedge clk);
      chk("timeout busy", busy, 0);
      send_bits(8'h1D, 1'b0, 1'b1, 11, 1'b0);
      repeat (10) @(negedge clk);
      exp_q.push_back('{1'b0, 2'b00, 8'h1D, 1'b0, 1'b0, 0});
      compare_events("after timeout 0x1D");
      chk("err_type hold after timeout", err_type, 2'b11);

      // Reset after the fifth data bit discards the partial frame.
      send_bits(8'h6B, 1'b0, 1'b1, 6, 1'b0);
      chk("pre-reset busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid-frame reset");
      kdata = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post-reset events", act_q.size(), 0);
      send_bits(8'h6B, 1'b0, 1'b1, 11, 1'b0);
      repeat (10) @(negedge clk);
      exp_q.push_back('{1'b0, 2'b00, 8'h6B, 1'b0, 1'b0, 0});
      compare_events("after reset 0x6B");

      // Random frames against the reference model.
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         bit         pf, st;
         int         r;
         r  = $urandom_range(0, 9);
         b  = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
         pf = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 7) != 0);
         model(b, pf, st);
         send_bits(b, pf, st, 11, 1'b0);
         repeat (10) @(negedge clk);
         compare_events($sformatf("rand%0d byte %0h", n, b));
      end

      chk("code_valid/frame_err overlap", excl_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_frame_decoder.md
Name: ps2_frame_decoder

Overview:
- Front-end stage that feeds the keyboard key-mapping logic.
- Brings the raw PS/2 clock and data lines into the onboard clock domain, then synchronises and glitch-filters them.
- Frames 11-bit PS/2 packets and checks start, odd parity and stop bits, with a timeout on stalled frames.
- Folds the E0 (extended) and F0 (break) prefix bytes into flags, so downstream logic receives one qualified scan-code event per key action.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes value (range 2..255).
- TIMEOUT_CYC, 200000: onboard-clock cycles allowed between two PS/2 falling edges inside a frame; 2 ms at 100 MHz.

Ports:
- clk  input  1  onboard system clock.
- rst_n  input  1  asynchronous active-low reset.
- keyb_clk  input  1  raw PS/2 clock from keyboard; asynchronous; idles high.
- kdata  input  1  raw PS/2 data from keyboard; asynchronous; idles high.
- code  output  8  scan code of the last completed key event.
- code_valid  output  1  one-cycle strobe; code, is_break and is_extended are valid in this cycle.
- is_break  output  1  event was preceded by F0 (key release).
- is_extended  output  1  event was preceded by E0.
- frame_err  output  1  one-cycle strobe on a rejected frame.
- err_type  output  2  01 parity, 10 stop bit, 11 timeout; holds its value until the next frame_err.
- busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset (async, rst_n low):
  - code=0, code_valid=0, is_break=0, is_extended=0, frame_err=0, err_type=0, busy=0.
  - Sync flops and filtered clock set to 1; FSM to IDLE; ext_pend=0, brk_pend=0; counters cleared.
  - Reset mid-frame discards the partial frame with no strobe.
- Synchronisation and filtering:
  - 2-FF synchroniser on each input.
  - Filtered clock takes the synchronised clock value only after FILTER_LEN consecutive equal samples; any mismatch restarts the count.
- Sample event: single-cycle pulse when the filtered clock goes 1->0. The synchronised data value in that same cycle is the sampled bit.
- FSM states IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample event with data=0 (start bit), go to DATA with bitcnt=0. A sample event with data=1 is ignored.
  - DATA: each sample event shifts the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: on the sample event, evaluate the frame and return to IDLE.
- Evaluation order:
  - Parity check first: the ones-count of the 8 data bits plus the parity bit must be odd; otherwise err_type=01.
  - Then the stop bit must be 1; otherwise err_type=10.
- Timeout:
  - Counter clears on every sample event and increments each cycle while busy.
  - Reaching TIMEOUT_CYC sets err_type=11 and returns to IDLE.
- Error handling: any error pulses frame_err for one cycle and clears ext_pend and brk_pend.
- Prefix layer, on each good byte:
  - E0: set ext_pend; no strobe.
  - F0: set brk_pend; no strobe.
  - Any other value: code<=byte, is_break<=brk_pend, is_extended<=ext_pend, code_valid=1 for one cycle, then clear both pendings.
  - Repeated prefix bytes are idempotent.
- Latency: code_valid or frame_err asserts in the cycle immediately after the stop-bit sample event (timeout: the cycle after the counter hits TIMEOUT_CYC).
- Output hold: code, is_break and is_extended hold their values between strobes.
- Exclusivity: code_valid and frame_err are never high together.
- Restart: a new start bit is accepted on the first sample event after returning to IDLE; no inter-frame gap is required.
- Host-to-device transmission is not supported; the block never drives the PS/2 lines.

Test Plan:
- Reset then clean frame 0x1C (start 0, data LSB-first, parity 0, stop 1), PS/2 clock half-period 4000 cycles -> one code_valid with code=0x1C, is_break=0, is_extended=0; frame_err never high.
- Byte sequence F0, 1C then E0, F0, 75 -> exactly two code_valid strobes: (0x1C, break=1, ext=0) and (0x75, break=1, ext=1); no strobes for prefix bytes.
- Frame 0x29 with parity bit 1 (even total) -> frame_err pulse, err_type=01, no code_valid. A following valid 0x29 frame -> code_valid with is_break=0.
- Start bit plus 4 data bits, then clock held high for 250000 cycles -> frame_err with err_type=11 at TIMEOUT_CYC after the last edge; busy falls; the next good 0x1D frame decodes normally.
- Glitch pulses of 5 cycles low on keyb_clk (FILTER_LEN=8) while idle and mid-frame -> no sample events; a frame of 0x23 decodes correctly with glitches interleaved.
- rst_n pulsed low after the 5th data bit of a frame -> all outputs 0 immediately; no strobe; the next complete 0x6B frame decodes correctly.
